mem_bus_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the shared 12-bit-address / 16-bit-data program/data memory.
- Requester 0 is the cpu memory port. Requester 1 is a secondary master such as a DMA engine or program loader.
- Grants the memory round-robin, drives the memory en/rdwr/ack handshake for one transaction at a time, and returns a registered one-cycle ack plus read data to the winner.
- Memory-side data is split into separate write and read buses; tristate glue to the inout memory data bus lives in the top level.

---
 rtl/mem_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared memory bus.
// Optional memory-ack watchdog enabled with `define ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_en,
  input  logic          r0_rdwr,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_en,
  input  logic          r1_rdwr,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_en,
  output logic          mem_rdwr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    gnt,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_rdwr_q, mem_rdwr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          r0_ack_q, r0_ack_d;
  logic          r1_ack_q, r1_ack_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d;
  logic [DW-1:0] r1_rdata_q, r1_rdata_d;
  logic          pick1;

`ifdef ARB_TIMEOUT_EN
  localparam int CLW = $clog2(TIMEOUT + 1);
  localparam int CW  = (CLW > 8) ? CLW : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Requester 1 wins if alone, or on contention when 0 was served last
  assign pick1 = r1_en && (!r0_en || !last_q);

  // Next-state, grant and transaction-completion logic
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_en_d    = mem_en_q;
    mem_rdwr_d  = mem_rdwr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = gnt_q;
    r0_ack_d    = 1'b0;
    r1_ack_d    = 1'b0;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (r0_en || r1_en) begin
          mem_en_d    = 1'b1;
          mem_rdwr_d  = pick1 ? r1_rdwr  : r0_rdwr;
          mem_addr_d  = pick1 ? r1_addr  : r0_addr;
          mem_wdata_d = pick1 ? r1_wdata : r0_wdata;
          gnt_d       = pick1 ? 2'b10    : 2'b01;
          last_d      = pick1;
          state_d     = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ack) begin
          mem_en_d = 1'b0;
          r0_ack_d = gnt_q[0];
          r1_ack_d = gnt_q[1];
          if (mem_rdwr_q && gnt_q[0]) r0_rdata_d = mem_rdata;
          if (mem_rdwr_q && gnt_q[1]) r1_rdata_d = mem_rdata;
          state_d  = DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_en_d = 1'b0;
          r0_ack_d = gnt_q[0];
          r1_ack_d = gnt_q[1];
          err_d    = 1'b1;
          if (mem_rdwr_q && gnt_q[0]) r0_rdata_d = '1;
          if (mem_rdwr_q && gnt_q[1]) r1_rdata_d = '1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        mem_en_d = 1'b0;
        gnt_d    = 2'b00;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any memory cycle at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_rdwr_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_q       <= 2'b00;
      r0_ack_q    <= 1'b0;
      r1_ack_q    <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_en_q    <= mem_en_d;
      mem_rdwr_q  <= mem_rdwr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_q       <= gnt_d;
      r0_ack_q    <= r0_ack_d;
      r1_ack_q    <= r1_ack_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Wait counter and error pulse for the memory-ack watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mem_en    = mem_en_q;
  assign mem_rdwr  = mem_rdwr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign gnt       = gnt_q;
  assign r0_ack    = r0_ack_q;
  assign r1_ack    = r1_ack_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a scoreboard of expected acks.
// Memory responder acks after a programmable number of mem_en cycles.
module tb_mem_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        rst;
  logic        r0_en, r0_rdwr, r0_ack;
  logic [11:0] r0_addr;
  logic [15:0] r0_wdata, r0_rdata;
  logic        r1_en, r1_rdwr, r1_ack;
  logic [11:0] r1_addr;
  logic [15:0] r1_wdata, r1_rdata;
  logic        mem_en, mem_rdwr, mem_ack;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  gnt;
  logic        err;

  mem_bus_arbiter #(.AW(12), .DW(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .r0_en(r0_en), .r0_rdwr(r0_rdwr), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_en(r1_en), .r1_rdwr(r1_rdwr), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_rdwr(mem_rdwr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .gnt(gnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [15:0] rd;
    logic        er;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] sh0, sh1;

  // Memory model and responder
  logic [15:0] mem [0:4095];
  int          lat;
  int          en_cyc;
  int          last_len;
  logic [11:0] la;
  logic [15:0] lw;
  logic        lr;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    en_cyc    = 0;
    last_len  = 0;
  end

  always @(negedge clk) begin
    if (!rst || !mem_en) begin
      if (en_cyc != 0) last_len = en_cyc;
      en_cyc  = 0;
      mem_ack = 1'b0;
    end else begin
      if (en_cyc == 0) begin
        la = mem_addr; lw = mem_wdata; lr = mem_rdwr;
      end else begin
        chk("stable_addr", mem_addr, la);
        chk("stable_wdata", mem_wdata, lw);
        chk("stable_rdwr", mem_rdwr, lr);
      end
      en_cyc++;
      mem_ack   = (lat != 0) && (en_cyc >= lat);
      mem_rdata = mem_rdwr ? mem[mem_addr] : 16'h0;
      if (mem_ack && !mem_rdwr) mem[mem_addr] = mem_wdata;
    end
  end

  // Ack monitor: pops the scoreboard on every completion pulse
  logic p0, p1;
  initial begin p0 = 1'b0; p1 = 1'b0; end

  always @(negedge clk) begin
    if (rst) begin
      if (r0_ack && p0) chk("ack0_width", 1, 0);
      if (r1_ack && p1) chk("ack1_width", 1, 0);
      if (r0_ack || r1_ack) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_ack", {r1_ack, r0_ack}, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_id", {r1_ack, r0_ack}, (mon_e.id == 1) ? 2 : 1);
          chk("ack_rdata", (mon_e.id == 1) ? r1_rdata : r0_rdata,
              mon_e.rd);
          chk("ack_err", err, mon_e.er);
          chk("ack_gnt", gnt, (mon_e.id == 1) ? 2 : 1);
        end
      end
    end
    p0 = r0_ack;
    p1 = r1_ack;
  end

  task automatic push(input int id, input logic rd,
                      input logic [15:0] d, input logic er);
    if (rd && id == 0) sh0 = d;
    if (rd && id == 1) sh1 = d;
    sb.push_back('{id: id, rd: (id == 1) ? sh1 : sh0, er: er});
  endtask

  task automatic wait_ack(input int id, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((id == 1) ? r1_ack : r0_ack) && n < 600);
    chk("ack_seen", (id == 1) ? r1_ack : r0_ack, 1);
    if (id == 1) r1_en = 1'b0;
    else r0_en = 1'b0;
  endtask

  task automatic do_req(input int id, input logic rd,
                        input logic [11:0] a, input logic [15:0] wd,
                        input logic [15:0] d, input int l,
                        input logic er);
    int n;
    @(posedge clk); #1;
    lat = l;
    if (id == 1) begin
      r1_en = 1'b1; r1_rdwr = rd; r1_addr = a; r1_wdata = wd;
    end else begin
      r0_en = 1'b1; r0_rdwr = rd; r0_addr = a; r0_wdata = wd;
    end
    push(id, rd, d, er);
    @(posedge clk); #1;
    chk("grant_mem_en", mem_en, 1);
    chk("grant_gnt", gnt, (id == 1) ? 2 : 1);
    chk("grant_addr", mem_addr, a);
    chk("grant_rdwr", mem_rdwr, rd);
    chk("grant_wdata", mem_wdata, wd);
    wait_ack(id, n);
    if (l != 0) chk("latency", n, l + 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int prev;
    int k;
    logic [1:0] gexp [6];

    rst = 1'b0; lat = 1;
    r0_en = 0; r0_rdwr = 0; r0_addr = '0; r0_wdata = '0;
    r1_en = 0; r1_rdwr = 0; r1_addr = '0; r1_wdata = '0;
    sh0 = 16'h0; sh1 = 16'h0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 7 + 3);
    mem[12'h010] = 16'h1234;
    mem[12'h020] = 16'hA5A5;
    mem[12'h030] = 16'h0F0F;
    mem[12'h155] = 16'h5555;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_rdwr", mem_rdwr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_r0_ack", r0_ack, 0);
    chk("rst_r1_ack", r1_ack, 0);
    chk("rst_r0_rdata", r0_rdata, 0);
    chk("rst_r1_rdata", r1_rdata, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;

    // First contention after reset: r0 first, then r1
    @(posedge clk); #1;
    lat = 1;
    r0_en = 1; r0_rdwr = 1; r0_addr = 12'h020;
    r1_en = 1; r1_rdwr = 1; r1_addr = 12'h030;
    push(0, 1, 16'hA5A5, 0);
    push(1, 1, 16'h0F0F, 0);
    gexp[0] = 2'b01; gexp[1] = 2'b01; gexp[2] = 2'b00;
    gexp[3] = 2'b10; gexp[4] = 2'b10; gexp[5] = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("contend_gnt", gnt, gexp[i]);
      @(negedge clk);
      if (r0_ack) r0_en = 1'b0;
      if (r1_ack) r1_en = 1'b0;
    end

    // Sustained contention: six alternating grants, 3 cycles apart
    @(posedge clk); #1;
    r0_en = 1; r1_en = 1;
    for (int i = 0; i < 6; i++)
      push(i % 2, 1, (i % 2) ? 16'h0F0F : 16'hA5A5, 0);
    k = 0; cyc = 0; prev = 0;
    while (k < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (r0_ack || r1_ack) begin
        if (k > 0) chk("sustain_spacing", cyc - prev, 3);
        prev = cyc;
        k++;
      end
    end
    chk("sustain_count", k, 6);
    r0_en = 0; r1_en = 0;

    // Read from r0, 1-cycle memory ack
    do_req(0, 1, 12'h010, 16'h0, 16'h1234, 1, 0);
    // Write from r1, 3-cycle memory ack; r1_rdata keeps last read
    do_req(1, 0, 12'h7FF, 16'hBEEF, 16'h0, 3, 0);
    @(posedge clk); #1;
    chk("write_en_len", last_len, 3);
    chk("write_mem", mem[12'h7FF], 16'hBEEF);
    // Read back the written word through r0
    do_req(0, 1, 12'h7FF, 16'h0, 16'hBEEF, 2, 0);

    // Reset in the middle of an r1 transaction
    @(posedge clk); #1;
    lat = 0;
    r1_en = 1; r1_rdwr = 1; r1_addr = 12'h155;
    @(posedge clk); #1;
    chk("mid_busy_gnt", gnt, 2'b10);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_r0_ack", r0_ack, 0);
    chk("mid_rst_r1_ack", r1_ack, 0);
    chk("mid_rst_r1_rdata", r1_rdata, 0);
    sb.delete();
    sh0 = 16'h0; sh1 = 16'h0;
    r0_en = 1; r0_rdwr = 1; r0_addr = 12'h010;
    lat = 1;
    push(0, 1, 16'h1234, 0);
    push(1, 1, 16'h5555, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_gnt", gnt, 2'b01);
    wait_ack(0, n);
    wait_ack(1, n);

`ifdef ARB_TIMEOUT_EN
    // Timeout: read with no memory ack
    do_req(0, 1, 12'h020, 16'h0, 16'hFFFF, 0, 1);
    @(posedge clk); #1;
    chk("to_en_len", last_len, TO);
    chk("to_idle_gnt", gnt, 0);
    chk("to_idle_mem_en", mem_en, 0);
    chk("to_err_clear", err, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    chk("final_gnt", gnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
